mem_io_responder: RTL and testbench
===================================

// Module: mem_io_responder
// PURPOSE
//  Bus-side responder for the processor memory interface (ADDR, DOUT, W out; DIN in).
//  Holds the program/data RAM, a LED output register, a synchronised switch input and a
//  countdown timer. All are memory-mapped and share one registered read path with 1-cycle latency.
//  It sits at top level between the processor and the board pins. It replaces the bare RAM + LED glue.
// PARAMETERS
//  RAM_AW    8      RAM address width; RAM depth = 2**RAM_AW 16-bit words
//  PRESCALE  50000  Clock cycles per timer tick (>=1); 1 ms at 50 MHz
// PORTS
//  Clock      in   1   system clock; all state changes on the rising edge
//  Resetn     in   1   asynchronous, active-low reset
//  ADDR       in   16  word address driven by the processor
//  DOUT       in   16  write data from the processor
//  W          in   1   write strobe; ADDR/DOUT are valid in the same cycle
//  DIN        out  16  registered read data to the processor
//  SW         in   10  board switches, asynchronous to Clock
//  LEDR       out  10  LED register
//  TIMER_EXP  out  1   copy of STATUS.EXP (sticky expiry flag)
// BEHAVIOUR
//  Address map, decoded on ADDR[15:12]:
//   0x0 RAM; index = ADDR[RAM_AW-1:0]; the region aliases modulo the depth.
//   0x1 LEDR: RW; bits [9:0]; bits [15:10] read as 0.
//   0x3 SW: RO; 2-flop synchronised SW, zero-extended.
//   0x4 timer, selected by ADDR[1:0]:
//       0 LOAD   RW
//       1 COUNT  RO
//       2 CTRL   RW; bit0 EN, bit1 AUTO
//       3 STATUS bit0 EXP; write 1 to clear
//   Any other region: reads return 0; writes are ignored.
//  Read path:
//   - No read strobe. Every cycle, DIN <= data(ADDR) at the rising edge.
//   - Data is therefore valid 1 cycle after ADDR. Reads have no side effects.
//  Write path:
//   - When W=1 at the edge, the selected target takes DOUT.
//   - A RAM read and write to the same address in the same cycle returns the OLD word
//     (read-before-write).
//   - Writing LOAD also sets COUNT to DOUT and clears the prescaler.
//   - Writing CTRL with EN going 0->1 clears the prescaler.
//  Timer (EN=1):
//   - The prescaler counts 0..PRESCALE-1. At wrap it produces one tick.
//   - On a tick with COUNT!=0: COUNT decrements.
//   - On a tick with COUNT==0: EXP<=1; if AUTO then COUNT<=LOAD, else EN<=0.
//   - EN=0 freezes both the prescaler and COUNT.
//  Simultaneous events:
//   - Expiry and STATUS write-1-clear in the same cycle: set wins, EXP=1.
//   - LOAD write and tick in the same cycle: the write wins and the tick is discarded.
//   - CTRL write and expiry clearing EN in the same cycle: the CTRL write wins.
//  Reset:
//   - Asserting Resetn=0 at any time immediately clears DIN, LEDR, the SW synchronisers,
//     LOAD, COUNT, CTRL, EXP, the prescaler and TIMER_EXP to 0.
//   - This holds even mid-countdown.
//   - RAM contents are not reset; the power-up value is undefined or comes from the init file.
// TESTING
//  1 Write 0x1234 to 0x0005 (W=1), then hold ADDR=0x0005 -> DIN=0x1234 on the next edge, not earlier.
//  2 Write 0x03FF to 0x1000, then read 0x1000 -> LEDR=0x3FF, DIN=0x03FF.
//    Then write 0xFFFF -> DIN reads 0x03FF.
//  3 SW=0x2A5 -> a read of 0x3000 returns 0x02A5 no earlier than the 3rd edge after SW changes.
//    A read of 0x2000 returns 0x0000.
//  4 PRESCALE=4: LOAD=2, CTRL=0x1 -> EXP and TIMER_EXP rise 12 cycles after the CTRL write; then EN=0 and COUNT=0.
//  5 AUTO: LOAD=1, CTRL=0x3 -> EXP set, COUNT reloads 1, and the timer keeps running.
//    Write 1 to STATUS on the expiry cycle -> EXP stays 1.
//  6 Pull Resetn low mid-countdown, between edges -> all outputs read 0 immediately.
//    After release, COUNT=0 and EN=0.

Source files
------------

// File: rtl/mem_io_responder_if.sv
// Processor-side memory bus: word address, write data and strobe out of the CPU,
// registered read data back in.
interface mem_io_responder_if;
    logic [15:0] ADDR;
    logic [15:0] DOUT;
    logic        W;
    logic [15:0] DIN;

    modport master (
        output ADDR,
        output DOUT,
        output W,
        input  DIN
    );

    modport slave (
        input  ADDR,
        input  DOUT,
        input  W,
        output DIN
    );
endinterface

// File: rtl/mem_io_responder.sv
// Memory-mapped responder: program/data RAM, LED register, synchronised switches and a
// countdown timer, all behind one registered read path with a single cycle of latency.
module mem_io_responder #(
    parameter int RAM_AW   = 8,
    parameter int PRESCALE = 50000
) (
    input  logic               Clock,
    input  logic               Resetn,
    mem_io_responder_if.slave  bus,
    input  logic [9:0]         SW,
    output logic [9:0]         LEDR,
    output logic               TIMER_EXP
);

    localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    localparam logic [3:0] REGION_RAM = 4'h0;
    localparam logic [3:0] REGION_LED = 4'h1;
    localparam logic [3:0] REGION_SW  = 4'h3;
    localparam logic [3:0] REGION_TMR = 4'h4;

    localparam logic [1:0] TMR_LOAD   = 2'd0;
    localparam logic [1:0] TMR_COUNT  = 2'd1;
    localparam logic [1:0] TMR_CTRL   = 2'd2;
    localparam logic [1:0] TMR_STATUS = 2'd3;

    logic [15:0]       ram_r [0:(2**RAM_AW)-1];
    logic [15:0]       din_r;
    logic [9:0]        led_r;
    logic [9:0]        sw_meta_r;
    logic [9:0]        sw_sync_r;
    logic [15:0]       load_r;
    logic [15:0]       count_r;
    logic              en_r;
    logic              auto_r;
    logic              exp_r;
    logic [PW-1:0]     pre_r;

    logic [3:0]        region_s;
    logic [1:0]        tmr_sel_s;
    logic [RAM_AW-1:0] ram_idx_s;
    logic [15:0]       rd_data_s;
    logic              wr_ram_s;
    logic              wr_led_s;
    logic              wr_load_s;
    logic              wr_ctrl_s;
    logic              wr_status_s;
    logic              pre_wrap_s;
    logic              tick_s;
    logic              expire_s;
    logic              en_rise_s;
    logic              unused_addr_s;

    assign region_s      = bus.ADDR[15:12];
    assign tmr_sel_s     = bus.ADDR[1:0];
    assign ram_idx_s     = bus.ADDR[RAM_AW-1:0];
    assign unused_addr_s = ^bus.ADDR;

    // Write strobes for each addressable target; unmapped regions get none.
    always_comb begin
        wr_ram_s    = 1'b0;
        wr_led_s    = 1'b0;
        wr_load_s   = 1'b0;
        wr_ctrl_s   = 1'b0;
        wr_status_s = 1'b0;
        if (bus.W) begin
            case (region_s)
                REGION_RAM: wr_ram_s = 1'b1;
                REGION_LED: wr_led_s = 1'b1;
                REGION_TMR: begin
                    case (tmr_sel_s)
                        TMR_LOAD:   wr_load_s   = 1'b1;
                        TMR_CTRL:   wr_ctrl_s   = 1'b1;
                        TMR_STATUS: wr_status_s = 1'b1;
                        default:    wr_load_s   = 1'b0;
                    endcase
                end
                default: wr_ram_s = 1'b0;
            endcase
        end else begin
            wr_ram_s = 1'b0;
        end
    end

    // Read mux sees pre-edge state, so a same-cycle write is observed one read later.
    always_comb begin
        rd_data_s = 16'h0000;
        case (region_s)
            REGION_RAM: rd_data_s = ram_r[ram_idx_s];
            REGION_LED: rd_data_s = {6'b000000, led_r};
            REGION_SW:  rd_data_s = {6'b000000, sw_sync_r};
            REGION_TMR: begin
                case (tmr_sel_s)
                    TMR_LOAD:   rd_data_s = load_r;
                    TMR_COUNT:  rd_data_s = count_r;
                    TMR_CTRL:   rd_data_s = {14'b00000000000000, auto_r, en_r};
                    TMR_STATUS: rd_data_s = {15'b000000000000000, exp_r};
                    default:    rd_data_s = 16'h0000;
                endcase
            end
            default: rd_data_s = 16'h0000;
        endcase
    end

    // A LOAD write discards any tick in the same cycle, including its expiry.
    always_comb begin
        pre_wrap_s = (pre_r == PRE_LAST);
        tick_s     = en_r && pre_wrap_s && !wr_load_s;
        expire_s   = tick_s && (count_r == 16'h0000);
        en_rise_s  = wr_ctrl_s && bus.DOUT[0] && !en_r;
    end

    // RAM write port; contents are deliberately left out of reset.
    always_ff @(posedge Clock) begin
        if (wr_ram_s) begin
            ram_r[ram_idx_s] <= bus.DOUT;
        end
    end

    // Registered read data.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            din_r <= 16'h0000;
        end else begin
            din_r <= rd_data_s;
        end
    end

    // LED register and two-flop switch synchroniser.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            led_r     <= 10'h000;
            sw_meta_r <= 10'h000;
            sw_sync_r <= 10'h000;
        end else begin
            sw_meta_r <= SW;
            sw_sync_r <= sw_meta_r;
            if (wr_led_s) begin
                led_r <= bus.DOUT[9:0];
            end
        end
    end

    // Prescaler: frozen while disabled, restarted by a LOAD write or an enable edge.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pre_r <= PW'(0);
        end else if (wr_load_s || en_rise_s) begin
            pre_r <= PW'(0);
        end else if (en_r) begin
            pre_r <= pre_wrap_s ? PW'(0) : pre_r + PW'(1);
        end
    end

    // Countdown, reload and control; a CTRL write overrides expiry clearing EN.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            load_r  <= 16'h0000;
            count_r <= 16'h0000;
            en_r    <= 1'b0;
            auto_r  <= 1'b0;
        end else begin
            if (wr_load_s) begin
                load_r  <= bus.DOUT;
                count_r <= bus.DOUT;
            end else if (tick_s) begin
                if (count_r != 16'h0000) begin
                    count_r <= count_r - 16'h0001;
                end else if (auto_r) begin
                    count_r <= load_r;
                end
            end

            if (wr_ctrl_s) begin
                en_r   <= bus.DOUT[0];
                auto_r <= bus.DOUT[1];
            end else if (expire_s && !auto_r) begin
                en_r <= 1'b0;
            end
        end
    end

    // Sticky expiry flag; setting beats a simultaneous write-1-clear.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            exp_r <= 1'b0;
        end else if (expire_s) begin
            exp_r <= 1'b1;
        end else if (wr_status_s && bus.DOUT[0]) begin
            exp_r <= 1'b0;
        end
    end

    assign bus.DIN   = din_r;
    assign LEDR      = led_r;
    assign TIMER_EXP = exp_r;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: reads push expected data into a scoreboard,
// a negedge monitor pops and compares once the one-cycle read latency has elapsed.
module tb_mem_io_responder;

    localparam int PRESC = 4;

    logic       Clock;
    logic       Resetn;
    logic [9:0] SW;
    logic [9:0] LEDR;
    logic       TIMER_EXP;
    logic       rd_req;
    logic       rd_vld = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_q [$];
    string       name_q [$];

    mem_io_responder_if bus ();

    mem_io_responder #(
        .RAM_AW   (8),
        .PRESCALE (PRESC)
    ) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .bus       (bus),
        .SW        (SW),
        .LEDR      (LEDR),
        .TIMER_EXP (TIMER_EXP)
    );

    always #5 Clock = ~Clock;

    function automatic void check(input string nm, input logic [15:0] act, input logic [15:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", nm, act, req);
        end
    endfunction

    // Read data becomes valid one edge after the address was presented.
    always @(posedge Clock) rd_vld <= rd_req;

    always @(negedge Clock) begin : monitor
        string       nm;
        logic [15:0] e;
        if (rd_vld) begin
            if (exp_q.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL sb_underflow: got DIN=0x%04h with no expected entry", bus.DIN);
            end else begin
                nm = name_q.pop_front();
                e  = exp_q.pop_front();
                check(nm, bus.DIN, e);
            end
        end
    end

    task automatic cyc(input logic [15:0] a, input logic [15:0] d, input logic w,
                       input logic rd, input logic [15:0] e, input string nm);
        bus.ADDR = a;
        bus.DOUT = d;
        bus.W    = w;
        rd_req   = rd;
        if (rd) begin
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
        @(posedge Clock);
        #1;
        bus.W  = 1'b0;
        rd_req = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        cyc(a, d, 1'b1, 1'b0, 16'h0000, "");
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] e, input string nm);
        cyc(a, 16'h0000, 1'b0, 1'b1, e, nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        Clock    = 1'b0;
        Resetn   = 1'b0;
        SW       = 10'h000;
        bus.ADDR = 16'h0000;
        bus.DOUT = 16'h0000;
        bus.W    = 1'b0;
        rd_req   = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        check("rst_din", bus.DIN, 16'h0000);
        check("rst_ledr", {6'b000000, LEDR}, 16'h0000);
        check("rst_timer_exp", {15'b0, TIMER_EXP}, 16'h0000);
        Resetn = 1'b1;
        @(posedge Clock);
        #1;

        // RAM: read-before-write, new data one read later, aliasing modulo depth
        wr(16'h0005, 16'h1111);
        cyc(16'h0005, 16'h1234, 1'b1, 1'b1, 16'h1111, "ram_rbw");
        rd(16'h0005, 16'h1234, "ram_new");
        rd(16'h0105, 16'h1234, "ram_alias");

        // LEDR register, upper bits masked
        wr(16'h1000, 16'h03FF);
        check("ledr_set", {6'b000000, LEDR}, 16'h03FF);
        rd(16'h1000, 16'h03FF, "led_rd");
        wr(16'h1000, 16'hFFFF);
        rd(16'h1000, 16'h03FF, "led_mask");
        check("ledr_mask", {6'b000000, LEDR}, 16'h03FF);

        // Switch synchroniser latency and unmapped region
        SW = 10'h2A5;
        rd(16'h3000, 16'h0000, "sw_edge1");
        rd(16'h3000, 16'h0000, "sw_edge2");
        rd(16'h3000, 16'h02A5, "sw_edge3");
        wr(16'h2000, 16'hBEEF);
        rd(16'h2000, 16'h0000, "unmapped");

        // One-shot timer: LOAD=2 with PRESCALE=4 expires 12 edges after CTRL write
        wr(16'h4000, 16'h0002);
        wr(16'h4002, 16'h0001);
        for (int i = 1; i <= 12; i++) begin
            rd(16'h4003, 16'h0000, "oneshot_status_wait");
            check("oneshot_timer_exp", {15'b0, TIMER_EXP}, (i == 12) ? 16'h0001 : 16'h0000);
        end
        rd(16'h4003, 16'h0001, "oneshot_status");
        rd(16'h4002, 16'h0000, "oneshot_ctrl_off");
        rd(16'h4001, 16'h0000, "oneshot_count");
        rd(16'h4000, 16'h0002, "oneshot_load");
        wr(16'h4003, 16'h0001);
        rd(16'h4003, 16'h0000, "status_clear");
        check("timer_exp_clear", {15'b0, TIMER_EXP}, 16'h0000);

        // Auto-reload timer, clear attempted on the expiry edge
        wr(16'h4000, 16'h0001);
        wr(16'h4002, 16'h0003);
        for (int i = 1; i <= 7; i++) begin
            rd(16'h4003, 16'h0000, "auto_status_wait");
            check("auto_timer_exp_wait", {15'b0, TIMER_EXP}, 16'h0000);
        end
        wr(16'h4003, 16'h0001);
        check("auto_set_wins", {15'b0, TIMER_EXP}, 16'h0001);
        rd(16'h4001, 16'h0001, "auto_reload");
        rd(16'h4002, 16'h0003, "auto_ctrl_on");
        rd(16'h4003, 16'h0001, "auto_exp_kept");
        rd(16'h4001, 16'h0001, "auto_count_before_tick");
        rd(16'h4001, 16'h0000, "auto_count_after_tick");

        // Asynchronous reset between edges, mid-countdown
        rd(16'h1000, 16'h03FF, "led_before_rst");
        @(negedge Clock);
        #2;
        check("din_before_rst", bus.DIN, 16'h03FF);
        check("timer_exp_before_rst", {15'b0, TIMER_EXP}, 16'h0001);
        Resetn = 1'b0;
        #1;
        check("async_rst_din", bus.DIN, 16'h0000);
        check("async_rst_ledr", {6'b000000, LEDR}, 16'h0000);
        check("async_rst_timer_exp", {15'b0, TIMER_EXP}, 16'h0000);
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
        rd(16'h4001, 16'h0000, "post_rst_count");
        rd(16'h4002, 16'h0000, "post_rst_ctrl");
        rd(16'h4003, 16'h0000, "post_rst_status");
        rd(16'h4000, 16'h0000, "post_rst_load");
        @(negedge Clock);
        #1;

        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL sb_drain: %0d expected reads never observed, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
